cdb_arbiter: RTL and testbench

Common data bus (CDB) arbiter for the Tomasulo core. It collects completed results from the four issue/execute paths: integer, load/store, multiply and divide. It buffers one result per path and grants one result per cycle in round-robin order. It drives the registered CDB that dispatch (tag match, register file and branch resolution) and the execution queues (operand wakeup) snoop.

---
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution path,
// round-robin grant, registered broadcast to dispatch and the queues.
module cdb_arbiter #(
    parameter int W_DATA = 32,
    parameter int W_TAG  = 6
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              int_valid,
    input  logic [W_TAG-1:0]  int_tag,
    input  logic [W_DATA-1:0] int_data,
    input  logic              int_branch,
    input  logic              int_taken,
    output logic              int_ready,

    input  logic              ls_valid,
    input  logic [W_TAG-1:0]  ls_tag,
    input  logic [W_DATA-1:0] ls_data,
    output logic              ls_ready,

    input  logic              mult_valid,
    input  logic [W_TAG-1:0]  mult_tag,
    input  logic [W_DATA-1:0] mult_data,
    output logic              mult_ready,

    input  logic              div_valid,
    input  logic [W_TAG-1:0]  div_tag,
    input  logic [W_DATA-1:0] div_data,
    output logic              div_ready,

    output logic              cdb_valid,
    output logic [W_TAG-1:0]  cdb_tag,
    output logic [W_DATA-1:0] cdb_data,
    output logic              cdb_branch,
    output logic              cdb_taken
);

    localparam int N = 4;

    logic [N-1:0]      in_valid;
    logic [W_TAG-1:0]  in_tag  [N];
    logic [W_DATA-1:0] in_data [N];

    logic [N-1:0]      hold_v;
    logic [W_TAG-1:0]  hold_tag  [N];
    logic [W_DATA-1:0] hold_data [N];
    logic              hold_branch;
    logic              hold_taken;

    logic [N-1:0]      ready;
    logic [N-1:0]      accept;
    logic [N-1:0]      grant;
    logic              found;
    logic [1:0]        gidx;
    logic [1:0]        idx;
    logic [1:0]        rr;

    assign in_valid = {div_valid, mult_valid, ls_valid, int_valid};

    assign in_tag[0]  = int_tag;
    assign in_tag[1]  = ls_tag;
    assign in_tag[2]  = mult_tag;
    assign in_tag[3]  = div_tag;

    assign in_data[0] = int_data;
    assign in_data[1] = ls_data;
    assign in_data[2] = mult_data;
    assign in_data[3] = div_data;

    // A slot being granted this cycle can take a new result on the same edge
    assign ready  = ~hold_v | grant;
    assign accept = in_valid & ready;

    assign int_ready  = ready[0];
    assign ls_ready   = ready[1];
    assign mult_ready = ready[2];
    assign div_ready  = ready[3];

    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = rr;
        idx   = rr;
        for (int i = 0; i < N; i++) begin
            idx = rr + 2'(i);
            if (!found && hold_v[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_v      <= '0;
            hold_branch <= 1'b0;
            hold_taken  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                hold_tag[i]  <= '0;
                hold_data[i] <= '0;
            end
        end else begin
            hold_v <= accept | (hold_v & ~grant);
            for (int i = 0; i < N; i++) begin
                if (accept[i]) begin
                    hold_tag[i]  <= in_tag[i];
                    hold_data[i] <= in_data[i];
                end
            end
            if (accept[0]) begin
                hold_branch <= int_branch;
                hold_taken  <= int_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr <= 2'd0;
        end else if (found) begin
            rr <= gidx + 2'd1;
        end
    end

    // Idle cycles drive all fields to zero so snoopers never see stale data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_branch <= 1'b0;
            cdb_taken  <= 1'b0;
        end else if (found) begin
            cdb_valid  <= 1'b1;
            cdb_tag    <= hold_tag[gidx];
            cdb_data   <= hold_data[gidx];
            cdb_branch <= grant[0] & hold_branch;
            cdb_taken  <= grant[0] & hold_branch & hold_taken;
        end else begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_branch <= 1'b0;
            cdb_taken  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are queued
// as stimulus is driven and popped as the CDB shows them.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_valid, int_branch, int_taken, int_ready;
    logic [5:0]  int_tag;
    logic [31:0] int_data;
    logic        ls_valid, ls_ready;
    logic [5:0]  ls_tag;
    logic [31:0] ls_data;
    logic        mult_valid, mult_ready;
    logic [5:0]  mult_tag;
    logic [31:0] mult_data;
    logic        div_valid, div_ready;
    logic [5:0]  div_tag;
    logic [31:0] div_data;
    logic        cdb_valid, cdb_branch, cdb_taken;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        br;
        logic        tk;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.W_DATA(32), .W_TAG(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .int_valid  (int_valid),
        .int_tag    (int_tag),
        .int_data   (int_data),
        .int_branch (int_branch),
        .int_taken  (int_taken),
        .int_ready  (int_ready),
        .ls_valid   (ls_valid),
        .ls_tag     (ls_tag),
        .ls_data    (ls_data),
        .ls_ready   (ls_ready),
        .mult_valid (mult_valid),
        .mult_tag   (mult_tag),
        .mult_data  (mult_data),
        .mult_ready (mult_ready),
        .div_valid  (div_valid),
        .div_tag    (div_tag),
        .div_data   (div_data),
        .div_ready  (div_ready),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .cdb_branch (cdb_branch),
        .cdb_taken  (cdb_taken)
    );

    function automatic logic [31:0] dat(input int t);
        return 32'hA500_0000 | 32'(t);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push(input int t, input logic [31:0] d,
                        input logic b, input logic k);
        exp_t e;
        e.tag  = 6'(t);
        e.data = d;
        e.br   = b;
        e.tk   = k;
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (cdb_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("cdb_tag", cdb_tag, e.tag);
                chk("cdb_data", cdb_data, e.data);
                chk("cdb_branch", cdb_branch, e.br);
                chk("cdb_taken", cdb_taken, e.tk);
            end
        end else begin
            chk("idle_zero", {cdb_tag, cdb_data, cdb_branch, cdb_taken}, 0);
        end
    endtask

    function automatic logic [3:0] rdy();
        return {int_ready, ls_ready, mult_ready, div_ready};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  tag_n;
        int  blk;
        int  maxblk;
        bit  acc;
        bit  lsacc;

        reset      = 1'b0;
        int_valid  = 1'b1; int_tag  = 6'd1; int_data  = dat(1);
        int_branch = 1'b1; int_taken = 1'b1;
        ls_valid   = 1'b1; ls_tag   = 6'd2; ls_data   = dat(2);
        mult_valid = 1'b1; mult_tag = 6'd3; mult_data = dat(3);
        div_valid  = 1'b1; div_tag  = 6'd4; div_data  = dat(4);
        #1;
        chk("rst_ready_async", rdy(), 4'hf);
        repeat (2) step();
        chk("rst_ready", rdy(), 4'hf);
        chk("rst_valid", cdb_valid, 0);

        // release with all four offering: four-way collision from rr=0
        reset = 1'b1;
        push(1, dat(1), 1'b1, 1'b1);
        push(2, dat(2), 1'b0, 1'b0);
        push(3, dat(3), 1'b0, 1'b0);
        push(4, dat(4), 1'b0, 1'b0);
        step();
        int_valid = 1'b0; ls_valid = 1'b0;
        mult_valid = 1'b0; div_valid = 1'b0;
        int_branch = 1'b0; int_taken = 1'b0;
        chk("rel_nobcast", cdb_valid, 0);
        chk("coll_ready0", rdy(), 4'b1000);
        step();
        chk("coll_v1", cdb_valid, 1);
        chk("coll_ready1", rdy(), 4'b1100);
        step();
        chk("coll_v2", cdb_valid, 1);
        chk("coll_ready2", rdy(), 4'b1110);
        step();
        chk("coll_v3", cdb_valid, 1);
        chk("coll_ready3", rdy(), 4'b1111);
        step();
        chk("coll_v4", cdb_valid, 1);
        step();
        chk("coll_end", cdb_valid, 0);
        chk("coll_q", sbq.size(), 0);

        // single uncontested result
        int_valid = 1'b1; int_tag = 6'h05; int_data = 32'hDEADBEEF;
        int_branch = 1'b1; int_taken = 1'b1;
        push(5, 32'hDEADBEEF, 1'b1, 1'b1);
        step();
        int_valid = 1'b0; int_branch = 1'b0; int_taken = 1'b0;
        chk("single_lat", cdb_valid, 0);
        step();
        chk("single_v", cdb_valid, 1);
        step();
        chk("single_once", cdb_valid, 0);

        // back-to-back refill on mult
        mult_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mult_tag  = 6'(30 + k);
            mult_data = dat(30 + k);
            push(30 + k, dat(30 + k), 1'b0, 1'b0);
            chk("b2b_ready", mult_ready, 1);
            step();
            if (k > 0) chk("b2b_cont", cdb_valid, 1);
        end
        mult_valid = 1'b0;
        step();
        chk("b2b_cont", cdb_valid, 1);
        step();
        chk("b2b_end", cdb_valid, 0);

        // reset mid-operation with ls and div held
        ls_valid  = 1'b1; ls_tag  = 6'd40; ls_data  = dat(40);
        div_valid = 1'b1; div_tag = 6'd41; div_data = dat(41);
        step();
        ls_valid = 1'b0; div_valid = 1'b0;
        chk("mid_full", {ls_ready, div_ready}, 2'b01);
        reset = 1'b0;
        #1;
        chk("mid_ready", rdy(), 4'hf);
        chk("mid_valid", cdb_valid, 0);
        step();
        reset = 1'b1;
        step();
        step();
        chk("mid_lost", cdb_valid, 0);
        chk("mid_ready2", rdy(), 4'hf);

        // round-robin fairness: int streams, ls holds one result
        int_valid = 1'b1; int_tag = 6'd10; int_data = dat(10);
        ls_valid  = 1'b1; ls_tag  = 6'd20; ls_data  = dat(20);
        push(10, dat(10), 1'b0, 1'b0);
        push(20, dat(20), 1'b0, 1'b0);
        for (int t = 11; t <= 14; t++) push(t, dat(t), 1'b0, 1'b0);
        tag_n  = 10;
        blk    = 0;
        maxblk = 0;
        for (int c = 0; c < 30 && (int_valid || sbq.size() > 0); c++) begin
            acc   = int_valid && int_ready;
            lsacc = ls_valid && ls_ready;
            if (int_valid && !int_ready) blk++;
            else blk = 0;
            if (blk > maxblk) maxblk = blk;
            step();
            if (lsacc) ls_valid = 1'b0;
            if (acc) begin
                if (tag_n == 14) begin
                    int_valid = 1'b0;
                end else begin
                    tag_n++;
                    int_tag  = 6'(tag_n);
                    int_data = dat(tag_n);
                end
            end
        end
        chk("rr_q", sbq.size(), 0);
        chk("rr_block", maxblk, 1);
        step();
        chk("rr_end", cdb_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
